// File: rtl/fft_seq_pkg.sv
// Shared types and address generation for the radix-2 DIT FFT stage sequencer.
package fft_seq_pkg;

    localparam int unsigned MAX_LOG2N = 11;
    localparam int unsigned ADDR_W    = MAX_LOG2N;
    localparam int unsigned TW_W      = ADDR_W - 1;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [TW_W-1:0]   tw;
    } addr_gen_t;

    // Butterfly k of stage s: legs are half apart inside a group of 2*half;
    // the twiddle stride shrinks by two per stage.
    function automatic addr_gen_t addr_gen(
        input logic [ADDR_W-1:0] k,
        input logic [3:0]        s,
        input logic [3:0]        l
    );
        addr_gen_t         r;
        logic [ADDR_W-1:0] half;
        logic [ADDR_W-1:0] pos;
        logic [ADDR_W-1:0] grp;
        half = ADDR_W'(1) << s;
        pos  = k & (half - ADDR_W'(1));
        grp  = k >> s;
        r.a  = (grp << ({1'b0, s} + 5'd1)) | pos;
        r.b  = r.a + half;
        r.tw = TW_W'(pos << (l - 4'd1 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_delay_line.sv
// Fixed-depth shift register aligning write-back strobes/addresses with the butterfly pipeline.
module fft_seq_delay_line #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 23
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = i_d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign o_q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: per-stage butterfly read, twiddle and write-back addressing.
// Optional macro FFT_SEQ_CYCLE_COUNT_EN adds the o_CYCLES run-length counter.
module fft_stage_sequencer #(
    parameter int unsigned MAX_LOG2N    = fft_seq_pkg::MAX_LOG2N,
    parameter int unsigned BFLY_LATENCY = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_START,
    input  logic [3:0]           i_LOG2N,
    input  logic                 i_CALC_ACK,
    output logic                 o_RD_EN,
    output logic [MAX_LOG2N-1:0] o_RD_ADDR_A,
    output logic [MAX_LOG2N-1:0] o_RD_ADDR_B,
    output logic [MAX_LOG2N-2:0] o_TW_INDEX,
    output logic                 o_WR_EN,
    output logic [MAX_LOG2N-1:0] o_WR_ADDR_A,
    output logic [MAX_LOG2N-1:0] o_WR_ADDR_B,
    output logic [3:0]           o_STAGE,
    output logic                 o_BUSY,
    output logic                 o_CALC_END,
    output logic                 o_ERR
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    ,
    output logic [23:0]          o_CYCLES
`endif
);
    import fft_seq_pkg::*;

    localparam int unsigned AW         = MAX_LOG2N;
    localparam int unsigned TWW        = MAX_LOG2N - 1;
    localparam int unsigned KW         = MAX_LOG2N - 1;
    localparam int unsigned DW         = 1 + 2 * AW;
    localparam logic [3:0]  DRAIN_LAST = 4'(BFLY_LATENCY - 1);

    seq_state_e    state_q, state_d;
    logic [3:0]    log2n_q, log2n_d;
    logic [3:0]    stage_q, stage_d;
    logic [3:0]    drain_q, drain_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] k_last;
    logic          err_q, err_d;
    logic          calc_end_q, calc_end_d;
    logic          rd_en;
    addr_gen_t     gen;
    logic [DW-1:0] wr_bus;

    assign k_last = KW'((32'd1 << (log2n_q - 4'd1)) - 32'd1);
    assign gen    = addr_gen(ADDR_W'(k_q), stage_q, log2n_q);

    always_comb begin
        state_d  = state_q;
        log2n_d  = log2n_q;
        stage_d  = stage_q;
        drain_d  = drain_q;
        k_d      = k_q;
        err_d    = err_q;
        rd_en    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                stage_d = '0;
                k_d     = '0;
                if (i_START) begin
                    log2n_d = i_LOG2N;
                    err_d   = 1'b0;
                    if (i_LOG2N == 4'd0 || 32'(i_LOG2N) > MAX_LOG2N) begin
                        err_d   = 1'b1;
                        state_d = SEQ_DONE;
                    end else begin
                        state_d = SEQ_RUN;
                    end
                end
            end
            SEQ_RUN: begin
                rd_en = 1'b1;
                if (k_q == k_last) begin
                    drain_d = '0;
                    state_d = SEQ_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            SEQ_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (stage_q == log2n_q - 4'd1) begin
                        state_d = SEQ_DONE;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        k_d     = '0;
                        state_d = SEQ_RUN;
                    end
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            SEQ_DONE: begin
                // ACK wins over a coincident start; the start is simply not looked at here.
                if (i_CALC_ACK) begin
                    stage_d = '0;
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
        calc_end_d = (state_d == SEQ_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= SEQ_IDLE;
            log2n_q    <= '0;
            stage_q    <= '0;
            drain_q    <= '0;
            k_q        <= '0;
            err_q      <= 1'b0;
            calc_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            log2n_q    <= log2n_d;
            stage_q    <= stage_d;
            drain_q    <= drain_d;
            k_q        <= k_d;
            err_q      <= err_d;
            calc_end_q <= calc_end_d;
        end
    end

    // Read-side outputs are forced to zero outside RUN so idle/reset buses stay quiet.
    assign o_RD_EN     = rd_en;
    assign o_RD_ADDR_A = rd_en ? AW'(gen.a) : '0;
    assign o_RD_ADDR_B = rd_en ? AW'(gen.b) : '0;
    assign o_TW_INDEX  = rd_en ? TWW'(gen.tw) : '0;

    fft_seq_delay_line #(
        .DEPTH (BFLY_LATENCY),
        .WIDTH (DW)
    ) u_wr_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({rd_en, o_RD_ADDR_A, o_RD_ADDR_B}),
        .o_q   (wr_bus)
    );

    assign {o_WR_EN, o_WR_ADDR_A, o_WR_ADDR_B} = wr_bus;

    assign o_STAGE    = stage_q;
    assign o_BUSY     = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
    assign o_CALC_END = calc_end_q;
    assign o_ERR      = err_q;

`ifdef FFT_SEQ_CYCLE_COUNT_EN
    logic [23:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (state_q == SEQ_IDLE && i_START) begin
            cycles_d = '0;
        end else if (o_BUSY) begin
            cycles_d = cycles_q + 24'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign o_CYCLES = cycles_q;
`endif

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Sequences the in-place radix-2 DIT FFT over the sample RAM once the AXI bridge reports the data is loaded.
- Per stage, generates butterfly read address pairs, the twiddle index, and the delayed write-back address pairs.
- Sits between the bridge (start via o_DATA_LOADED, completion via i_CALC_END) and the butterfly datapath and RAM ports.
- Asserts a level "calculation finished" flag that the bridge waits on before reading results out.

Parameters:
MAX_LOG2N, 11, largest supported log2(N); address width is MAX_LOG2N bits.
BFLY_LATENCY, 4, butterfly pipeline depth in cycles from RAM read issue to result write; legal range 1..15.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_START  in  1  start pulse, driven by the bridge's o_DATA_LOADED
i_LOG2N  in  4  transform size exponent, captured at start
i_CALC_ACK  in  1  bridge has consumed the results; clears o_CALC_END
o_RD_EN  out  1  butterfly operand read strobe
o_RD_ADDR_A  out  MAX_LOG2N  upper-leg read address
o_RD_ADDR_B  out  MAX_LOG2N  lower-leg read address
o_TW_INDEX  out  MAX_LOG2N-1  twiddle ROM index, valid with o_RD_EN
o_WR_EN  out  1  result write strobe
o_WR_ADDR_A  out  MAX_LOG2N  upper-leg write address
o_WR_ADDR_B  out  MAX_LOG2N  lower-leg write address
o_STAGE  out  4  current stage number
o_BUSY  out  1  high in RUN or DRAIN
o_CALC_END  out  1  level flag: transform complete
o_ERR  out  1  sticky: last start had an illegal i_LOG2N

Behaviour:
- Reset: state IDLE; all outputs 0; counters and delay line cleared. Reset mid-run aborts immediately, with no further writes.
- Notation: L = captured i_LOG2N, N = 2^L, s = stage (0..L-1), k = butterfly (0..N/2-1).
- Address and twiddle generation:
  - half = 1<<s; pos = k & (half-1); grp = k>>s.
  - RD_ADDR_A = (grp<<(s+1)) | pos; RD_ADDR_B = RD_ADDR_A + half.
  - TW_INDEX = pos << (L-1-s).
  - All values are zero-extended to full width.
- FSM:
  - IDLE: on i_START, capture L and clear o_ERR. If L==0 or L>MAX_LOG2N, set o_ERR and go to DONE with no RAM access. Otherwise go to RUN with s=0, k=0.
  - RUN: one butterfly per cycle. o_RD_EN=1 and k increments. After k==N/2-1, go to DRAIN.
  - DRAIN: exactly BFLY_LATENCY cycles with o_RD_EN=0. Then, if s==L-1, go to DONE; else increment s, set k=0, and go to RUN.
  - DONE: o_CALC_END=1 (registered) and held. On i_CALC_ACK, clear it and go to IDLE.
- Write path: {o_WR_EN, o_WR_ADDR_A, o_WR_ADDR_B} equals {o_RD_EN, o_RD_ADDR_A, o_RD_ADDR_B} delayed exactly BFLY_LATENCY cycles.
- Hazard rule: the last write of stage s occurs in the final DRAIN cycle, strictly before the first read of stage s+1.
- Timing: start-to-o_CALC_END = L*(N/2+BFLY_LATENCY)+1 cycles. i_START is sampled in cycle 0; RUN begins in cycle 1.
- i_START outside IDLE is ignored. i_CALC_ACK outside DONE is ignored.
- i_START and i_CALC_ACK together in DONE: the ACK wins and the start is dropped.
- o_STAGE is held at the last stage value in DONE and reset to 0 in IDLE.

Optional Feature:
FFT_SEQ_CYCLE_COUNT_EN
- Defined: adds output o_CYCLES[23:0]. It clears on an accepted start, increments every cycle in RUN/DRAIN, and holds in DONE/IDLE.
- Undefined: the port and its counter are absent.

Decomposition:
- Package fft_seq_pkg:
  - seq_state_e enum (SEQ_IDLE, SEQ_RUN, SEQ_DRAIN, SEQ_DONE).
  - ADDR_W and TW_W localparams derived from MAX_LOG2N.
  - Address-generation function (k, s, L) -> {a, b, tw}.
- Sub-module fft_seq_delay_line: parameterised shift register of depth BFLY_LATENCY carrying {en, addr_a, addr_b}, asynchronously cleared by i_rst.

Test Plan:
1. N=8 (L=3), BFLY_LATENCY=2.
   - Read pairs:
     - stage0: (0,1) (2,3) (4,5) (6,7)
     - stage1: (0,2) (1,3) (4,6) (5,7)
     - stage2: (0,4) (1,5) (2,6) (3,7)
   - TW_INDEX per stage: 0,0,0,0 / 0,2,0,2 / 0,1,2,3.
   - o_CALC_END rises at cycle 19.
2. Same run: each o_WR_* equals o_RD_* from 2 cycles earlier; no stage-(s+1) read before the last stage-s write.
3. i_LOG2N=0 and i_LOG2N=12 -> o_ERR=1, o_CALC_END=1 next cycle, o_RD_EN and o_WR_EN never asserted.
4. i_START pulsed during RUN (N=16) -> ignored; the sequence completes at the normal cycle count of 4*(8+BFLY_LATENCY)+1.
5. i_rst asserted mid stage1 -> all outputs 0 asynchronously; no o_WR_EN after release; the next start runs cleanly.
6. DONE with i_START and i_CALC_ACK both high -> IDLE, no new run. With FFT_SEQ_CYCLE_COUNT_EN, o_CYCLES=18 after the N=8 run.
